best_score_tracker: RTL

Pipelined, parametrised best-score tracker for the hash-search datapath. Each cycle it accepts up to LANES candidate scores (bit-difference counts), each with a tag (nonce/candidate index), and reduces them to the lane minimum. It then compares that minimum against a held best score and updates the score/tag pair when the candidate is better. It is the multi-lane, registered, mode-selectable successor of the fixed 10-bit single-compare select logic, and it feeds result readout and host polling.

---
 rtl/best_score_tracker_pkg.sv | 12 +
 rtl/best_score_tracker_lt_compare.sv | 17 +
 rtl/best_score_tracker.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/best_score_tracker_pkg.sv
// Shared constants for the best-score tracker: default widths and the
// all-ones "nothing found yet" best score.
package best_score_tracker_pkg;

  localparam int DEF_SCORE_W = 10;
  localparam int DEF_TAG_W   = 32;
  localparam int DEF_LANES   = 4;

  // All-ones best value at the default score width; any real score ties or beats it.
  localparam logic [DEF_SCORE_W-1:0] SCORE_MAX = '1;

endpackage

// File: rtl/best_score_tracker_lt_compare.sv
// Unsigned "is a better than b" compare: strict less-than, or
// less-than-or-equal when le_mode_i is set.
module lt_compare #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             le_mode_i,
  output logic             lt_o
);

  // Select between the two unsigned orderings.
  always_comb begin
    lt_o = le_mode_i ? (a_i <= b_i) : (a_i < b_i);
  end

endmodule

// File: rtl/best_score_tracker.sv
// Multi-lane best-score tracker: register the lanes (S1), reduce them to the
// lane minimum (S2), then compare and update the held best pair (S3).
module best_score_tracker
  import best_score_tracker_pkg::*;
#(
  parameter int SCORE_W = DEF_SCORE_W,
  parameter int TAG_W   = DEF_TAG_W,
  parameter int LANES   = DEF_LANES
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [LANES-1:0]         valid_i,
  input  logic [LANES*SCORE_W-1:0] score_i,
  input  logic [LANES*TAG_W-1:0]   tag_i,
  input  logic                     le_mode_i,
  input  logic                     load_i,
  input  logic [SCORE_W-1:0]       load_score_i,
  output logic [SCORE_W-1:0]       best_score_o,
  output logic [TAG_W-1:0]         best_tag_o,
  output logic                     best_valid_o,
  output logic                     new_best_o,
  output logic                     busy_o
);

  // Heap-ordered tree: node 0 is the root, leaves sit at LANES-1 .. 2*LANES-2
  // in lane order, so a left child always covers lower lane indices.
  localparam int NODES = 2 * LANES - 1;

  logic [LANES-1:0]         s1Valid_q;
  logic [LANES*SCORE_W-1:0] s1Score_q;
  logic [LANES*TAG_W-1:0]   s1Tag_q;
  logic                     s1Le_q;

  logic                     s2Valid_q;
  logic [SCORE_W-1:0]       s2Score_q;
  logic [TAG_W-1:0]         s2Tag_q;
  logic                     s2Le_q;

  logic [SCORE_W-1:0]       bestScore_q, bestScore_d;
  logic [TAG_W-1:0]         bestTag_q, bestTag_d;
  logic                     bestValid_q, bestValid_d;
  logic                     newBest_q, newBest_d;

  logic                     nodeValid [NODES];
  logic [SCORE_W-1:0]       nodeScore [NODES];
  logic [TAG_W-1:0]         nodeTag   [NODES];

  logic                     candBetter;
  logic                     candAccept;

  // S1: capture every lane together with the compare mode it must use later.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1Valid_q <= '0;
      s1Score_q <= '0;
      s1Tag_q   <= '0;
      s1Le_q    <= 1'b0;
    end else begin
      s1Valid_q <= valid_i;
      s1Score_q <= score_i;
      s1Tag_q   <= tag_i;
      s1Le_q    <= le_mode_i;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : gLeaf
    assign nodeValid[LANES-1+k] = s1Valid_q[k];
    assign nodeScore[LANES-1+k] = s1Score_q[k*SCORE_W +: SCORE_W];
    assign nodeTag[LANES-1+k]   = s1Tag_q[k*TAG_W +: TAG_W];
  end

  // Each node keeps the left (lower-lane) child unless the right child is
  // valid and strictly smaller, or the left child carries no candidate.
  for (genvar n = 0; n < LANES - 1; n++) begin : gNode
    logic leftLt;
    logic pickRight;

    lt_compare #(.WIDTH(SCORE_W)) uNodeCmp (
      .a_i       (nodeScore[2*n+1]),
      .b_i       (nodeScore[2*n+2]),
      .le_mode_i (1'b0),
      .lt_o      (leftLt)
    );

    assign pickRight = nodeValid[2*n+2] &&
                       (!nodeValid[2*n+1] ||
                        (!leftLt && (nodeScore[2*n+1] != nodeScore[2*n+2])));
    assign nodeValid[n] = nodeValid[2*n+1] | nodeValid[2*n+2];
    assign nodeScore[n] = pickRight ? nodeScore[2*n+2] : nodeScore[2*n+1];
    assign nodeTag[n]   = pickRight ? nodeTag[2*n+2]   : nodeTag[2*n+1];
  end

  // S2: register the lane minimum; an all-invalid cycle leaves S2 empty.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2Valid_q <= 1'b0;
      s2Score_q <= '0;
      s2Tag_q   <= '0;
      s2Le_q    <= 1'b0;
    end else begin
      s2Valid_q <= nodeValid[0];
      s2Score_q <= nodeScore[0];
      s2Tag_q   <= nodeTag[0];
      s2Le_q    <= s1Le_q;
    end
  end

  // S3 compares against the live best register, so consecutive candidates
  // always see the result of the previous update.
  lt_compare #(.WIDTH(SCORE_W)) uBestCmp (
    .a_i       (s2Score_q),
    .b_i       (bestScore_q),
    .le_mode_i (s2Le_q),
    .lt_o      (candBetter)
  );

  assign candAccept = s2Valid_q & candBetter;

  // Next best pair: a threshold load overrides any accept in the same cycle.
  always_comb begin
    bestScore_d = bestScore_q;
    bestTag_d   = bestTag_q;
    bestValid_d = bestValid_q;
    newBest_d   = 1'b0;
    if (load_i) begin
      bestScore_d = load_score_i;
      bestTag_d   = '0;
      bestValid_d = 1'b0;
    end else if (candAccept) begin
      bestScore_d = s2Score_q;
      bestTag_d   = s2Tag_q;
      bestValid_d = 1'b1;
      newBest_d   = 1'b1;
    end
  end

  // Best register; reset outranks load and drops whatever was in flight.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bestScore_q <= '1;
      bestTag_q   <= '0;
      bestValid_q <= 1'b0;
      newBest_q   <= 1'b0;
    end else begin
      bestScore_q <= bestScore_d;
      bestTag_q   <= bestTag_d;
      bestValid_q <= bestValid_d;
      newBest_q   <= newBest_d;
    end
  end

  assign best_score_o = bestScore_q;
  assign best_tag_o   = bestTag_q;
  assign best_valid_o = bestValid_q;
  assign new_best_o   = newBest_q;
  assign busy_o       = (|s1Valid_q) | s2Valid_q;

endmodule
